// File: rtl/cellrv32_package.sv
// cellrv32_package: shared IO map, ICAP register layout and sizing helpers.
package cellrv32_package;

  function automatic int index_size_f(input int n);
    for (int i = 0; i < 32; i++) if ((1 << i) >= n) return i;
    return 32;
  endfunction

  localparam logic [31:0] io_base_c = 32'hFFFFFE00;
  localparam int          io_size_c = 512;

  localparam logic [31:0] icap_base_c       = 32'hFFFFFF60;
  localparam int          icap_size_c       = 16;
  localparam logic [31:0] icap_ctrl_addr_c  = icap_base_c + 32'd0;
  localparam logic [31:0] icap_count_addr_c = icap_base_c + 32'd4;
  localparam logic [31:0] icap_data_addr_c  = icap_base_c + 32'd8;

  localparam int ctrl_en_c     = 0;
  localparam int ctrl_prsc0_c  = 1;
  localparam int ctrl_prsc2_c  = 3;
  localparam int ctrl_edge0_c  = 4;
  localparam int ctrl_edge1_c  = 5;
  localparam int ctrl_clr_c    = 6;
  localparam int ctrl_ovf_c    = 7;
  localparam int ctrl_avail_c  = 8;
  localparam int ctrl_full_c   = 9;
  localparam int ctrl_level0_c = 10;
  localparam int ctrl_level4_c = 14;

endpackage

// File: rtl/cellrv32_icap_fifo.sv
// cellrv32_icap_fifo: power-of-two timestamp queue with flush; full when pointers differ only in the MSB.
module cellrv32_icap_fifo
  import cellrv32_package::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW = index_size_f(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  localparam int         IW  = (AW > 0) ? AW : 1;
  localparam logic [AW:0] MSB = (AW + 1)'(1 << AW);

  logic [AW:0]      wp_q, wp_d, rp_q, rp_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             we;

  function automatic logic [IW-1:0] idx(input logic [AW:0] p);
    return (AW == 0) ? '0 : IW'(p);
  endfunction

  always_comb begin
    full_o  = (wp_q ^ rp_q) == MSB;
    empty_o = wp_q == rp_q;
    level_o = wp_q - rp_q;
    we      = push_i & ~full_o & ~clr_i;
    wp_d    = clr_i ? '0 : wp_q + (AW + 1)'(we);
    rp_d    = clr_i ? '0 : rp_q + (AW + 1)'(pop_i & ~empty_o);
    rdata_o = mem_q[idx(rp_q)];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) mem_q[idx(wp_q)] <= wdata_i;
  end

endmodule

// File: rtl/cellrv32_icap.sv
// cellrv32_icap: input capture unit; timestamps a prescaled counter on selected edges of capture_i.
module cellrv32_icap
  import cellrv32_package::*;
#(
  parameter int ICAP_FIFO = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] addr_i,
  input  logic        rden_i,
  input  logic        wren_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        clkgen_en_o,
  input  logic [7:0]  clkgen_i,
  input  logic        capture_i,
  output logic        irq_o
);

  localparam int HI = index_size_f(io_size_c) - 1;
  localparam int LO = index_size_f(icap_size_c);
  localparam int LW = index_size_f(ICAP_FIFO) + 1;

  if (ICAP_FIFO < 1 || ICAP_FIFO > 16 || (ICAP_FIFO & (ICAP_FIFO - 1)) != 0) begin : g_chk
    $error("cellrv32_icap: ICAP_FIFO must be a power of two in 1..16");
  end

  logic          acc_en, rden, wren, wr_ctrl, wr_cnt, rd_data, clr, rise, fall, evt;
  logic          full, empty;
  logic [LW-1:0] level;
  logic [31:0]   head, ctrl_w, rdata;
  logic [1:0]    sel;
  logic          unused_addr;

  logic        en_q, en_d, ovf_q, ovf_d, cnt_we_q, cnt_we_d, tick_q, tick_d;
  logic        ack_q, ack_d, irq_q, irq_d;
  logic [2:0]  prsc_q, prsc_d, s_q, s_d;
  logic [1:0]  edge_q, edge_d;
  logic [31:0] cnt_q, cnt_d, cnt_wd_q, cnt_wd_d, data_q, data_d;

  assign unused_addr = ^{addr_i[31:HI+1], addr_i[1:0]};

  always_comb begin
    acc_en   = addr_i[HI:LO] == icap_base_c[HI:LO];
    rden     = acc_en & rden_i;
    wren     = acc_en & wren_i;
    sel      = addr_i[LO-1:2];
    wr_ctrl  = wren & (sel == icap_ctrl_addr_c[LO-1:2]);
    wr_cnt   = wren & (sel == icap_count_addr_c[LO-1:2]);
    rd_data  = rden & (sel == icap_data_addr_c[LO-1:2]);
    clr      = wr_ctrl & data_i[ctrl_clr_c];
    rise     = s_q[1] & ~s_q[2];
    fall     = ~s_q[1] & s_q[2];
    evt      = en_q & ((edge_q[0] & rise) | (edge_q[1] & fall));
    en_d     = wr_ctrl ? data_i[ctrl_en_c] : en_q;
    prsc_d   = wr_ctrl ? data_i[ctrl_prsc2_c:ctrl_prsc0_c] : prsc_q;
    edge_d   = wr_ctrl ? data_i[ctrl_edge1_c:ctrl_edge0_c] : edge_q;
    ovf_d    = clr ? 1'b0 : (evt & full) ? 1'b1 : ovf_q;
    cnt_we_d = wr_cnt;
    cnt_wd_d = data_i;
    tick_d   = clkgen_i[prsc_q];
    cnt_d    = cnt_we_q ? cnt_wd_q : (en_q & tick_q) ? cnt_q + 32'd1 : cnt_q;
    s_d      = {s_q[1:0], capture_i};
    ctrl_w   = '0;
    ctrl_w[ctrl_en_c]                   = en_q;
    ctrl_w[ctrl_prsc2_c:ctrl_prsc0_c]   = prsc_q;
    ctrl_w[ctrl_edge1_c:ctrl_edge0_c]   = edge_q;
    ctrl_w[ctrl_ovf_c]                  = ovf_q;
    ctrl_w[ctrl_avail_c]                = ~empty;
    ctrl_w[ctrl_full_c]                 = full;
    ctrl_w[ctrl_level4_c:ctrl_level0_c] = 5'(level);
    rdata    = (sel == icap_ctrl_addr_c[LO-1:2])  ? ctrl_w :
               (sel == icap_count_addr_c[LO-1:2]) ? cnt_q :
               (sel == icap_data_addr_c[LO-1:2])  ? (empty ? 32'd0 : head) : 32'd0;
    data_d   = rden ? rdata : 32'd0;
    ack_d    = rden | wren;
    irq_d    = en_q & ~empty;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      en_q     <= 1'b0;
      prsc_q   <= '0;
      edge_q   <= '0;
      ovf_q    <= 1'b0;
      cnt_we_q <= 1'b0;
      cnt_wd_q <= '0;
      tick_q   <= 1'b0;
      cnt_q    <= '0;
      s_q      <= '0;
      data_q   <= '0;
      ack_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      en_q     <= en_d;
      prsc_q   <= prsc_d;
      edge_q   <= edge_d;
      ovf_q    <= ovf_d;
      cnt_we_q <= cnt_we_d;
      cnt_wd_q <= cnt_wd_d;
      tick_q   <= tick_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      data_q   <= data_d;
      ack_q    <= ack_d;
      irq_q    <= irq_d;
    end
  end

  cellrv32_icap_fifo #(.DEPTH(ICAP_FIFO), .WIDTH(32)) u_fifo (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (clr),
    .push_i (evt),
    .pop_i  (rd_data),
    .wdata_i(cnt_q),
    .rdata_o(head),
    .full_o (full),
    .empty_o(empty),
    .level_o(level)
  );

  assign data_o      = data_q;
  assign ack_o       = ack_q;
  assign irq_o       = irq_q;
  assign clkgen_en_o = en_q;

endmodule

// File: tb/tb_cellrv32_icap.sv
// tb_cellrv32_icap: directed register-level checks of capture, FIFO boundaries, counter wrap and reset.
module tb_cellrv32_icap;

  localparam logic [31:0] CTRL = 32'hFFFFFF60;
  localparam logic [31:0] CNT  = 32'hFFFFFF64;
  localparam logic [31:0] DAT  = 32'hFFFFFF68;

  logic        clk = 1'b0, rstn = 1'b0, rden = 1'b0, wren = 1'b0, cap = 1'b0;
  logic [31:0] addr = '0, wdat = '0;
  logic [7:0]  clkgen = '0;
  logic [31:0] data_o;
  logic        ack_o, clkgen_en_o, irq_o;
  int          vec = 0, err = 0;

  cellrv32_icap #(.ICAP_FIFO(4)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .addr_i     (addr),
    .rden_i     (rden),
    .wren_i     (wren),
    .data_i     (wdat),
    .data_o     (data_o),
    .ack_o      (ack_o),
    .clkgen_en_o(clkgen_en_o),
    .clkgen_i   (clkgen),
    .capture_i  (cap),
    .irq_o      (irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdat = d; wren = 1'b1;
    @(negedge clk);
    wren = 1'b0;
    chk("wr_ack", {31'd0, ack_o}, 32'd1);
    @(negedge clk);
    chk("wr_ack_off", {31'd0, ack_o}, 32'd0);
  endtask

  task automatic rdc(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    addr = a; rden = 1'b1;
    chk("rd_ack_pre", {31'd0, ack_o}, 32'd0);
    @(negedge clk);
    rden = 1'b0;
    chk("rd_ack", {31'd0, ack_o}, 32'd1);
    chk(tag, data_o, exp);
    @(negedge clk);
    chk("rd_idle", data_o, 32'd0);
  endtask

  task automatic pulse(input logic [7:0] m);
    @(negedge clk);
    clkgen = m;
    @(negedge clk);
    clkgen = 8'h00;
    cyc(2);
  endtask

  task automatic push_ts(input logic [31:0] v);
    wr(CNT, v);
    cap = ~cap;
    cyc(4);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(1);
    chk("rst_data", data_o, 32'd0);
    chk("rst_ack", {31'd0, ack_o}, 32'd0);
    chk("rst_irq", {31'd0, irq_o}, 32'd0);
    chk("rst_clkgen_en", {31'd0, clkgen_en_o}, 32'd0);
    rstn = 1'b1;
    rdc("rst_ctrl", CTRL, 32'd0);
    rdc("rst_count", CNT, 32'd0);
    rdc("rst_fifo", DAT, 32'd0);

    // single rising-edge capture with static counter
    wr(CTRL, 32'h11);
    chk("en_clkgen", {31'd0, clkgen_en_o}, 32'd1);
    wr(CNT, 32'h100);
    rdc("count_load", CNT, 32'h100);
    cap = 1'b1;
    cyc(3);
    chk("irq_latency_early", {31'd0, irq_o}, 32'd0);
    cyc(1);
    chk("irq_set", {31'd0, irq_o}, 32'd1);
    rdc("ctrl_level1", CTRL, 32'h511);
    rdc("data_first", DAT, 32'h100);
    chk("irq_drained", {31'd0, irq_o}, 32'd0);
    cap = 1'b0;
    cyc(5);
    chk("fall_ignored", {31'd0, irq_o}, 32'd0);

    // both edges, overflow at depth 4
    wr(CTRL, 32'h31);
    for (int k = 0; k < 6; k++) push_ts(32'h1000 + k);
    rdc("ctrl_full_ovf", CTRL, 32'h13B1);
    rdc("pop0", DAT, 32'h1000);
    rdc("pop1", DAT, 32'h1001);
    rdc("pop2", DAT, 32'h1002);
    rdc("pop3", DAT, 32'h1003);
    rdc("pop_empty", DAT, 32'h0);
    rdc("ovf_sticky", CTRL, 32'hB1);
    wr(CTRL, 32'h71);
    rdc("clr_ovf", CTRL, 32'h31);

    // counter wrap and capture of the wrapped value
    wr(CTRL, 32'h01);
    wr(CNT, 32'hFFFFFFFE);
    pulse(8'h01);
    rdc("cnt_max", CNT, 32'hFFFFFFFF);
    pulse(8'h01);
    rdc("cnt_wrap", CNT, 32'h0);
    wr(CTRL, 32'h11);
    wr(CNT, 32'hFFFFFFFF);
    pulse(8'h01);
    cap = 1'b1;
    cyc(5);
    rdc("wrap_cap_level", CTRL, 32'h511);
    rdc("wrap_cap_value", DAT, 32'h0);
    rdc("wrap_cap_popped", CTRL, 32'h11);

    // prescaler select and hold while disabled
    wr(CTRL, 32'h07);
    wr(CNT, 32'h50);
    pulse(8'h01);
    rdc("prsc_other_tick", CNT, 32'h50);
    pulse(8'h08);
    rdc("prsc_sel_tick", CNT, 32'h51);
    wr(CTRL, 32'h06);
    chk("dis_clkgen", {31'd0, clkgen_en_o}, 32'd0);
    pulse(8'h08);
    rdc("hold_disabled", CNT, 32'h51);

    // pop coinciding with push at level 2
    wr(CTRL, 32'h31);
    push_ts(32'hA0);
    push_ts(32'hA1);
    wr(CNT, 32'hA2);
    cap = ~cap;
    cyc(2);
    addr = DAT; rden = 1'b1;
    cyc(1);
    rden = 1'b0;
    chk("pushpop_head", data_o, 32'hA0);
    cyc(1);
    rdc("pushpop_level", CTRL, 32'h931);
    rdc("pushpop_next", DAT, 32'hA1);
    rdc("pushpop_new", DAT, 32'hA2);

    // clear coinciding with push
    for (int k = 0; k < 5; k++) push_ts(32'hC0 + k);
    rdc("ovf_pre_clr", DAT, 32'hC0);
    wr(CNT, 32'hC9);
    cap = ~cap;
    cyc(2);
    addr = CTRL; wdat = 32'h71; wren = 1'b1;
    cyc(1);
    wren = 1'b0;
    cyc(1);
    rdc("clr_wins", CTRL, 32'h31);
    rdc("clr_empty", DAT, 32'h0);

    // asynchronous reset mid-operation
    push_ts(32'hD0);
    push_ts(32'hD1);
    push_ts(32'hD2);
    chk("pre_rst_irq", {31'd0, irq_o}, 32'd1);
    chk("pre_rst_clkgen", {31'd0, clkgen_en_o}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("async_irq", {31'd0, irq_o}, 32'd0);
    chk("async_clkgen", {31'd0, clkgen_en_o}, 32'd0);
    chk("async_data", data_o, 32'd0);
    cyc(2);
    rstn = 1'b1;
    rdc("post_rst_ctrl", CTRL, 32'd0);
    rdc("post_rst_count", CNT, 32'd0);
    rdc("post_rst_fifo", DAT, 32'd0);
    pulse(8'hFF);
    rdc("post_rst_hold", CNT, 32'd0);
    chk("post_rst_irq", {31'd0, irq_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
